// File: rtl/address_generator.sv
// Modulo address counter for the LDPC message RAM: starts at COUNT_FROM, wraps at COUNT_MOD.
// Define ADDRGEN_STATUS_EN to build the wrap pulse and pass counter; otherwise those outputs tie to 0.
module address_generator #(
   parameter int DATA_WIDTH = 8,
   parameter int COUNT_FROM = 8,
   parameter int COUNT_MOD  = 256,
   parameter int PASS_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   output logic [DATA_WIDTH-1:0] out,
   output logic                  wrap,
   output logic [PASS_WIDTH-1:0] pass_cnt
);

   localparam longint MOD_LIMIT = longint'(1) << DATA_WIDTH;

   generate
      if (COUNT_MOD < 2 || longint'(COUNT_MOD) > MOD_LIMIT) begin : g_bad_mod
         $error("address_generator: COUNT_MOD must be in 2..2**DATA_WIDTH");
      end
      if (COUNT_FROM < 0 || COUNT_FROM >= COUNT_MOD) begin : g_bad_from
         $error("address_generator: COUNT_FROM must be in 0..COUNT_MOD-1");
      end
      if (DATA_WIDTH < 1 || PASS_WIDTH < 1) begin : g_bad_width
         $error("address_generator: widths must be at least 1");
      end
   endgenerate

   localparam logic [DATA_WIDTH-1:0] LAST_ADDR  = DATA_WIDTH'(COUNT_MOD - 1);
   localparam logic [DATA_WIDTH-1:0] START_ADDR = DATA_WIDTH'(COUNT_FROM);

   logic [DATA_WIDTH-1:0] out_reg;
   logic [DATA_WIDTH-1:0] out_next;
   logic                  at_last;
   logic                  wrap_next;

   // Explicit terminal compare so non-power-of-two block sizes wrap correctly.
   always_comb begin
      at_last   = (out_reg == LAST_ADDR);
      wrap_next = en && at_last;
      out_next  = out_reg;
      if (en) begin
         out_next = at_last ? '0 : out_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_reg <= START_ADDR;
      end else begin
         out_reg <= out_next;
      end
   end

   assign out = out_reg;

`ifdef ADDRGEN_STATUS_EN
   logic                  wrap_reg;
   logic [PASS_WIDTH-1:0] pass_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wrap_reg <= 1'b0;
         pass_reg <= '0;
      end else begin
         wrap_reg <= wrap_next;
         if (wrap_next) begin
            pass_reg <= pass_reg + 1'b1;
         end
      end
   end

   assign wrap     = wrap_reg;
   assign pass_cnt = pass_reg;
`else
   logic unused_status;
   assign unused_status = wrap_next;
   assign wrap          = 1'b0;
   assign pass_cnt      = '0;
`endif

endmodule

// File: tb/tb_address_generator.sv
// Self-checking bench for address_generator: three parameterisations share clock, reset and enable,
// checked against an arithmetic model driven by the number of enabled edges since reset.
module tb_address_generator;

`ifdef ADDRGEN_STATUS_EN
   localparam bit STATUS = 1'b1;
`else
   localparam bit STATUS = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   logic en;

   logic [7:0] out0, out1, out2;
   logic       wrap0, wrap1, wrap2;
   logic [3:0] pass0, pass1;
   logic [1:0] pass2;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   address_generator #(.DATA_WIDTH(8), .COUNT_FROM(8), .COUNT_MOD(256), .PASS_WIDTH(4)) dut0 (
      .clk(clk), .reset(reset), .en(en), .out(out0), .wrap(wrap0), .pass_cnt(pass0));
   address_generator #(.DATA_WIDTH(8), .COUNT_FROM(7), .COUNT_MOD(10), .PASS_WIDTH(4)) dut1 (
      .clk(clk), .reset(reset), .en(en), .out(out1), .wrap(wrap1), .pass_cnt(pass1));
   address_generator #(.DATA_WIDTH(8), .COUNT_FROM(0), .COUNT_MOD(4), .PASS_WIDTH(2)) dut2 (
      .clk(clk), .reset(reset), .en(en), .out(out2), .wrap(wrap2), .pass_cnt(pass2));

   int from_p[3] = '{8, 7, 0};
   int mod_p[3]  = '{256, 10, 4};
   int pw_p[3]   = '{4, 4, 2};

   // Model state: enabled edges since reset, and whether the latest edge was enabled.
   int k;
   bit last_en;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         k       = 0;
         last_en = 1'b0;
      end else if (en) begin
         k       = k + 1;
         last_en = 1'b1;
      end else begin
         last_en = 1'b0;
      end
   end

   function automatic int exp_out(int i);
      return (from_p[i] + k) % mod_p[i];
   endfunction

   function automatic int exp_wrap(int i);
      return (STATUS && last_en && k > 0 && exp_out(i) == 0) ? 1 : 0;
   endfunction

   function automatic int exp_pass(int i);
      return STATUS ? ((from_p[i] + k) / mod_p[i]) % (1 << pw_p[i]) : 0;
   endfunction

   function automatic int get_out(int i);
      return (i == 0) ? int'(out0) : (i == 1) ? int'(out1) : int'(out2);
   endfunction

   function automatic int get_wrap(int i);
      return (i == 0) ? int'(wrap0) : (i == 1) ? int'(wrap1) : int'(wrap2);
   endfunction

   function automatic int get_pass(int i);
      return (i == 0) ? int'(pass0) : (i == 1) ? int'(pass1) : int'(pass2);
   endfunction

   task automatic test_reset();
      reset = 1'b0;
      en    = 1'b1;
      repeat (15) begin
         @(negedge clk);
         compared++;
         if (out0 !== 8'd8 || wrap0 !== 1'b0 || pass0 !== 4'd0) begin
            mismatched++;
            $display("FAIL reset_hold t=%0t: out=%0d wrap=%0d pass=%0d, required out=8 wrap=0 pass=0",
                     $time, out0, wrap0, pass0);
         end
      end
      reset = 1'b1;
      $display("test_reset: done at %0t", $time);
   endtask

   task automatic test_count_release();
      repeat (5) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            compared++;
            if (get_out(i) !== exp_out(i) || get_wrap(i) !== exp_wrap(i) || get_pass(i) !== exp_pass(i)) begin
               mismatched++;
               $display("FAIL count_release dut%0d t=%0t: out=%0d wrap=%0d pass=%0d, required %0d/%0d/%0d",
                        i, $time, get_out(i), get_wrap(i), get_pass(i), exp_out(i), exp_wrap(i), exp_pass(i));
            end
         end
      end
      compared++;
      if (out0 !== 8'h0d) begin
         mismatched++;
         $display("FAIL count_0xD: out=%0h, required 0d", out0);
      end
      $display("test_count_release: out0=%0h at %0t", out0, $time);
   endtask

   task automatic test_async_reset();
      reset = 1'b0;
      #1;
      compared++;
      if (out0 !== 8'd8 || out1 !== 8'd7 || out2 !== 8'd0) begin
         mismatched++;
         $display("FAIL async_reset: outs=%0d/%0d/%0d, required 8/7/0", out0, out1, out2);
      end
      repeat (8) @(negedge clk);
      compared++;
      if (out0 !== 8'd8 || wrap0 !== 1'b0 || pass0 !== 4'd0) begin
         mismatched++;
         $display("FAIL async_hold: out=%0d wrap=%0d pass=%0d, required 8/0/0", out0, wrap0, pass0);
      end
      reset = 1'b1;
      @(negedge clk);
      compared++;
      if (out0 !== 8'd9) begin
         mismatched++;
         $display("FAIL async_rerelease: out=%0d, required 9", out0);
      end
      $display("test_async_reset: re-released, out0=%0d at %0t", out0, $time);
   endtask

   task automatic test_enable_gating();
      int n = 0;
      while (exp_out(0) != 32 && n < 300) begin
         @(negedge clk);
         n++;
      end
      compared++;
      if (n >= 300 || out0 !== 8'h20) begin
         mismatched++;
         $display("FAIL gate_reach: out=%0h after %0d cycles, required 20", out0, n);
      end
      en = 1'b0;
      repeat (3) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            compared++;
            if (get_out(i) !== exp_out(i) || get_wrap(i) !== 0 || get_pass(i) !== exp_pass(i)) begin
               mismatched++;
               $display("FAIL gate_hold dut%0d: out=%0d wrap=%0d pass=%0d, required %0d/0/%0d",
                        i, get_out(i), get_wrap(i), get_pass(i), exp_out(i), exp_pass(i));
            end
         end
      end
      compared++;
      if (out0 !== 8'h20) begin
         mismatched++;
         $display("FAIL gate_hold_0x20: out=%0h, required 20", out0);
      end
      en = 1'b1;
      @(negedge clk);
      compared++;
      if (out0 !== 8'h21) begin
         mismatched++;
         $display("FAIL gate_resume: out=%0h, required 21", out0);
      end
      $display("test_enable_gating: resumed out0=%0h", out0);
   endtask

   task automatic test_wrap();
      int seq[5]  = '{7, 8, 9, 0, 1};
      int wseq[5] = '{0, 0, 0, 1, 0};
      int pseq[5] = '{0, 0, 0, 1, 1};
      @(negedge clk);
      reset = 1'b0;
      #1 reset = 1'b1;
      en = 1'b1;
      #1;
      for (int s = 0; s < 5; s++) begin
         if (s > 0) @(negedge clk);
         compared++;
         if (out1 !== 8'(seq[s]) || wrap1 !== 1'(STATUS && wseq[s] == 1) ||
             pass1 !== 4'(STATUS ? pseq[s] : 0)) begin
            mismatched++;
            $display("FAIL wrap_mod10 step%0d: out=%0d wrap=%0d pass=%0d, required %0d/%0d/%0d",
                     s, out1, wrap1, pass1, seq[s], STATUS ? wseq[s] : 0, STATUS ? pseq[s] : 0);
         end
      end
      $display("test_wrap: mod-10 sequence stepped");
   endtask

   task automatic test_rollover();
      int pulses = 0;
      int pexp[4] = '{1, 2, 3, 0};
      @(negedge clk);
      reset = 1'b0;
      #1 reset = 1'b1;
      en = 1'b1;
      repeat (16) begin
         @(negedge clk);
         if (wrap2 === 1'b1) begin
            compared++;
            if (pass2 !== 2'(pexp[pulses % 4])) begin
               mismatched++;
               $display("FAIL rollover_pass pulse%0d: pass=%0d, required %0d", pulses, pass2, pexp[pulses % 4]);
            end
            pulses++;
         end
      end
      compared++;
      if (pulses != (STATUS ? 4 : 0) || pass2 !== 2'd0 || out2 !== 8'd0) begin
         mismatched++;
         $display("FAIL rollover_total: pulses=%0d pass=%0d out=%0d, required %0d/0/0",
                  pulses, pass2, out2, STATUS ? 4 : 0);
      end
      $display("test_rollover: %0d wrap pulses", pulses);
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            compared++;
            if (get_out(i) !== exp_out(i) || get_wrap(i) !== exp_wrap(i) || get_pass(i) !== exp_pass(i)) begin
               mismatched++;
               $display("FAIL random c%0d dut%0d: out=%0d wrap=%0d pass=%0d, required %0d/%0d/%0d",
                        c, i, get_out(i), get_wrap(i), get_pass(i), exp_out(i), exp_wrap(i), exp_pass(i));
            end
         end
         en = ($urandom_range(0, 4) != 0);
         if ($urandom_range(0, 39) == 0) begin
            #2 reset = 1'b0;
            #1;
            compared++;
            if (out0 !== 8'd8 || out1 !== 8'd7 || wrap1 !== 1'b0 || pass1 !== 4'd0 || pass2 !== 2'd0) begin
               mismatched++;
               $display("FAIL random_reset c%0d: out0=%0d out1=%0d wrap1=%0d pass1=%0d pass2=%0d",
                        c, out0, out1, wrap1, pass1, pass2);
            end
            #1 reset = 1'b1;
         end
      end
      $display("test_random: 400 cycles");
   endtask

   initial begin
      reset = 1'b0;
      en    = 1'b1;
      test_reset();
      test_count_release();
      test_async_reset();
      test_enable_gating();
      test_wrap();
      test_rollover();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
